// File: rtl/ste_shift_reg_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : ste_shift_reg_mc_if
// Brief    : Parallel-load and received-word handshakes of ste_shift_reg_mc.
// Revision : 1.0
// ============================================================================
interface ste_shift_reg_mc_if #(
    parameter int SHIFT_W = 24
) ();
    logic [SHIFT_W-1:0] din_parallel_i;
    logic               ld_valid_i;
    logic               ld_ready_o;
    logic [SHIFT_W-1:0] word_o;
    logic               word_valid_o;
    logic               word_ready_i;

    modport master (
        output din_parallel_i,
        output ld_valid_i,
        input  ld_ready_o,
        input  word_o,
        input  word_valid_o,
        output word_ready_i
    );

    modport slave (
        input  din_parallel_i,
        input  ld_valid_i,
        output ld_ready_o,
        output word_o,
        output word_valid_o,
        input  word_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/ste_shift_reg_mc.sv
`default_nettype none
// ============================================================================
// Module   : ste_shift_reg_mc
// Brief    : Multi-lane full-duplex serial/parallel shifter with word handshake.
// Revision : 1.0
// ============================================================================
module ste_shift_reg_mc #(
    parameter  int SHIFT_W = 24,
    parameter  int LANES   = 1,
    localparam int STEPS   = SHIFT_W / LANES,
    localparam int CNT_W   = $clog2(STEPS + 1)
) (
    input  wire logic               clk,
    input  wire logic               reset_ni,
    input  wire logic               shift_clr_i,
    input  wire logic               cfg_msb_first_i,
    input  wire logic               shift_en_i,
    input  wire logic [LANES-1:0]   din_i,
    output logic      [LANES-1:0]   dout_o,
    output logic      [SHIFT_W-1:0] dout_parallel_o,
    output logic      [CNT_W-1:0]   step_cnt_o,
    output logic                    overrun_o,
    ste_shift_reg_mc_if.slave       bus
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    logic [SHIFT_W-1:0] shift_q;
    logic [CNT_W-1:0]   step_cnt;
    logic               msb_first_q;
    logic [SHIFT_W-1:0] word_q;
    logic               word_valid_q;
    logic               overrun_q;

    logic [SHIFT_W-1:0] shift_msb;
    logic [SHIFT_W-1:0] shift_lsb;
    logic [SHIFT_W-1:0] shift_next;
    logic               at_boundary;
    logic               load;
    logic               shift;
    logic               word_done;
    logic               word_take;

    // A single-step word replaces the whole register with the lanes.
    generate
        if (STEPS == 1) begin : g_single_step
            assign shift_msb = din_i;
            assign shift_lsb = din_i;
        end else begin : g_multi_step
            assign shift_msb = {shift_q[SHIFT_W-LANES-1:0], din_i};
            assign shift_lsb = {din_i, shift_q[SHIFT_W-1:LANES]};
        end
    endgenerate

    always_comb begin
        at_boundary = (step_cnt == '0);
        bus.ld_ready_o = reset_ni & ~shift_clr_i & at_boundary;
        load        = bus.ld_valid_i & bus.ld_ready_o;
        shift       = shift_en_i & ~shift_clr_i & ~load;
        shift_next  = msb_first_q ? shift_msb : shift_lsb;
        word_done   = shift & (step_cnt == LAST_STEP);
        // A completed word is dropped only if the previous one is still held.
        word_take   = ~word_valid_q | bus.word_ready_i;
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            shift_q     <= '0;
            step_cnt    <= '0;
            msb_first_q <= 1'b1;
        end else if (shift_clr_i) begin
            shift_q     <= '0;
            step_cnt    <= '0;
            msb_first_q <= cfg_msb_first_i;
        end else if (load) begin
            shift_q     <= bus.din_parallel_i;
            msb_first_q <= cfg_msb_first_i;
        end else if (shift) begin
            shift_q  <= shift_next;
            step_cnt <= word_done ? '0 : step_cnt + 1'b1;
        end else if (at_boundary) begin
            msb_first_q <= cfg_msb_first_i;
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            word_q       <= '0;
            word_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (shift_clr_i) begin
            word_q       <= '0;
            word_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (word_done) begin
            if (word_take) begin
                word_q       <= shift_next;
                word_valid_q <= 1'b1;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (word_valid_q && bus.word_ready_i) begin
            word_valid_q <= 1'b0;
        end
    end

    assign dout_o           = msb_first_q ? shift_q[SHIFT_W-1 -: LANES] : shift_q[LANES-1:0];
    assign dout_parallel_o  = shift_q;
    assign step_cnt_o       = step_cnt;
    assign overrun_o        = overrun_q;
    assign bus.word_o       = word_q;
    assign bus.word_valid_o = word_valid_q;

endmodule
`default_nettype wire
